hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the decode stage. It keeps a scoreboard of in-flight destination registers, detects RAW hazards against the register-file read ports, and holds fetch/decode while it injects NOP bubbles into ID/EX.
- It serialises branches and jumps until EX resolves them, and drains the pipeline on HALT.
- It sits beside decode and replaces the ad-hoc stall logic. Its bubble output drives the control unit's NOP substitution.

---
 rtl/hazard_ctrl_pkg.sv | 31 +++
 rtl/hazard_scoreboard.sv | 75 +++++++
 rtl/hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard controller: FSM state
// encoding, scoreboard slot layout and the NOP instruction word.
package hazard_ctrl_pkg;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        BR_WAIT = 2'b01,
        DRAIN   = 2'b10,
        HALTED  = 2'b11
    } state_e;

    // Widest register address a slot can hold; narrower addresses are
    // zero-extended so the slot layout stays fixed across configurations.
    localparam int RA_W_MAX = 8;

    // One in-flight destination register entry.
    typedef struct packed {
        logic                v;
        logic [RA_W_MAX-1:0] rd;
    } slot_t;

    // Instruction word the control unit substitutes for a bubble.
    localparam logic [15:0] NOP_INSTR = 16'h0800;

    // True when a slot holds a live write to the given register.
    function automatic logic slot_hit(input slot_t slot, input logic [RA_W_MAX-1:0] ra);
        return slot.v & (slot.rd == ra);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight destination registers plus the two read-port
// comparators. raw flags a dependency on a result not yet visible in the
// register file; empty means no write is still in flight.
module hazard_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter int RA_W      = 3,
    parameter int WB_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [RA_W-1:0] push_rd,
    input  logic            chk_en,
    input  logic [RA_W-1:0] rs,
    input  logic            use_rs,
    input  logic [RA_W-1:0] rt,
    input  logic            use_rt,
    output logic            raw,
    output logic            empty
);

    // With a forwarding register file the oldest slot is already readable.
    localparam int CMP_N = DEPTH - WB_BYPASS;

    slot_t               slot_r [DEPTH];
    logic [RA_W_MAX-1:0] push_rd_ext_s;
    logic [RA_W_MAX-1:0] rs_ext_s;
    logic [RA_W_MAX-1:0] rt_ext_s;
    logic                hit_rs_s;
    logic                hit_rt_s;
    logic                empty_s;

    assign push_rd_ext_s = RA_W_MAX'(push_rd);
    assign rs_ext_s      = RA_W_MAX'(rs);
    assign rt_ext_s      = RA_W_MAX'(rt);

    // Advance every in-flight write one stage; slot 0 takes the issuing writer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_r[i] <= '0;
            end
        end else begin
            slot_r[0].v  <= push;
            slot_r[0].rd <= push ? push_rd_ext_s : '0;
            for (int i = 1; i < DEPTH; i++) begin
                slot_r[i] <= slot_r[i-1];
            end
        end
    end

    // Compare both read ports against the slots still hidden from the register file.
    always_comb begin
        hit_rs_s = 1'b0;
        hit_rt_s = 1'b0;
        for (int i = 0; i < CMP_N; i++) begin
            hit_rs_s = hit_rs_s | slot_hit(slot_r[i], rs_ext_s);
            hit_rt_s = hit_rt_s | slot_hit(slot_r[i], rt_ext_s);
        end
    end

    // Pipeline is drained only when no slot, including the oldest, is live.
    always_comb begin
        empty_s = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            empty_s = empty_s & ~slot_r[i].v;
        end
    end

    assign raw   = chk_en & ((use_rs & hit_rs_s) | (use_rt & hit_rt_s));
    assign empty = empty_s;

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage sequencing controller: stalls on RAW hazards, serialises
// branches/jumps until EX resolves them and drains the pipeline on HALT.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter int RA_W      = 3,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_regwrt,
    input  logic             id_ctrl,
    input  logic             id_halt,
    input  logic             ex_resolve,
    input  logic             ex_redirect,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_kill,
    output logic             idex_bubble,
    output logic             pc_sel_ex,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e           state_r;
    state_e           state_s;
    logic             kill_s;
    logic             raw_s;
    logic             empty_s;
    logic             issue_s;
    logic             push_s;
    logic             pc_hold_s;
    logic             ifid_hold_s;
    logic             idex_bubble_s;
    logic             pc_sel_ex_s;
    logic             halted_s;
    logic [CNT_W-1:0] stall_cnt_r;

    // IF/ID holds a wrong-path fetch for as long as a branch is unresolved.
    assign kill_s  = (state_r == BR_WAIT);
    assign issue_s = id_valid & ~kill_s & ~raw_s & (state_r == RUN);
    // HALT never occupies a slot even if its decode claims a write.
    assign push_s  = issue_s & id_regwrt & ~id_halt;

    hazard_scoreboard #(
        .DEPTH     (DEPTH),
        .RA_W      (RA_W),
        .WB_BYPASS (WB_BYPASS)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .push_rd (id_rd),
        .chk_en  (id_valid & ~kill_s),
        .rs      (id_rs),
        .use_rs  (id_use_rs),
        .rt      (id_rt),
        .use_rt  (id_use_rt),
        .raw     (raw_s),
        .empty   (empty_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and pipeline control outputs; HALT outranks branch/jump.
    always_comb begin
        state_s       = state_r;
        pc_hold_s     = 1'b0;
        ifid_hold_s   = 1'b0;
        idex_bubble_s = 1'b1;
        pc_sel_ex_s   = 1'b0;
        halted_s      = 1'b0;
        case (state_r)
            RUN: begin
                pc_hold_s     = raw_s;
                ifid_hold_s   = raw_s;
                idex_bubble_s = ~(issue_s & ~id_halt);
                if (issue_s & id_halt) begin
                    state_s = DRAIN;
                end else if (issue_s & id_ctrl) begin
                    state_s = BR_WAIT;
                end else begin
                    state_s = RUN;
                end
            end
            BR_WAIT: begin
                pc_sel_ex_s = ex_resolve & ex_redirect;
                if (ex_resolve) begin
                    state_s = RUN;
                end else begin
                    state_s = BR_WAIT;
                end
            end
            DRAIN: begin
                pc_hold_s   = 1'b1;
                ifid_hold_s = 1'b1;
                if (empty_s) begin
                    state_s = HALTED;
                end else begin
                    state_s = DRAIN;
                end
            end
            HALTED: begin
                pc_hold_s   = 1'b1;
                ifid_hold_s = 1'b1;
                halted_s    = 1'b1;
                state_s     = HALTED;
            end
            default: begin
                state_s = RUN;
            end
        endcase
    end

    // Count bubble cycles up to saturation; the parked HALTED state is not a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= '0;
        end else if (idex_bubble_s && (state_r != HALTED) && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign pc_hold     = pc_hold_s;
    assign ifid_hold   = ifid_hold_s;
    assign ifid_kill   = kill_s;
    assign idex_bubble = idex_bubble_s;
    assign pc_sel_ex   = pc_sel_ex_s;
    assign halted      = halted_s;
    assign stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Instance a uses the default configuration;
// instance b has no write-back bypass and a 3-bit counter for saturation.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid = 1'b0;
    logic [2:0] id_rs = 3'd0;
    logic [2:0] id_rt = 3'd0;
    logic       id_use_rs = 1'b0;
    logic       id_use_rt = 1'b0;
    logic [2:0] id_rd = 3'd0;
    logic       id_regwrt = 1'b0;
    logic       id_ctrl = 1'b0;
    logic       id_halt = 1'b0;
    logic       ex_resolve = 1'b0;
    logic       ex_redirect = 1'b0;

    logic        a_pc_hold, a_ifid_hold, a_ifid_kill, a_idex_bubble, a_pc_sel_ex, a_halted;
    logic [15:0] a_stall_cnt;
    logic        b_pc_hold, b_ifid_hold, b_ifid_kill, b_idex_bubble, b_pc_sel_ex, b_halted;
    logic [2:0]  b_stall_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.DEPTH(3), .RA_W(3), .WB_BYPASS(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_regwrt(id_regwrt),
        .id_ctrl(id_ctrl), .id_halt(id_halt), .ex_resolve(ex_resolve), .ex_redirect(ex_redirect),
        .pc_hold(a_pc_hold), .ifid_hold(a_ifid_hold), .ifid_kill(a_ifid_kill),
        .idex_bubble(a_idex_bubble), .pc_sel_ex(a_pc_sel_ex), .halted(a_halted),
        .stall_cnt(a_stall_cnt)
    );

    hazard_ctrl #(.DEPTH(3), .RA_W(3), .WB_BYPASS(0), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_regwrt(id_regwrt),
        .id_ctrl(id_ctrl), .id_halt(id_halt), .ex_resolve(ex_resolve), .ex_redirect(ex_redirect),
        .pc_hold(b_pc_hold), .ifid_hold(b_ifid_hold), .ifid_kill(b_ifid_kill),
        .idex_bubble(b_idex_bubble), .pc_sel_ex(b_pc_sel_ex), .halted(b_halted),
        .stall_cnt(b_stall_cnt)
    );

    // Single comparison point: counts and reports.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Control vector order: {pc_hold, ifid_hold, ifid_kill, idex_bubble, pc_sel_ex}.
    task automatic chk_a(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, a_pc_hold, a_ifid_hold, a_ifid_kill, a_idex_bubble, a_pc_sel_ex}, {27'd0, exp});
    endtask

    task automatic chk_b(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, b_pc_hold, b_ifid_hold, b_ifid_kill, b_idex_bubble, b_pc_sel_ex}, {27'd0, exp});
    endtask

    // Present an instruction in ID, then let combinational outputs settle.
    task automatic ins(input logic v, input logic [2:0] rs, input logic urs,
                       input logic [2:0] rt, input logic urt, input logic [2:0] rd,
                       input logic rw, input logic ct, input logic hl);
        id_valid  = v;
        id_rs     = rs;
        id_use_rs = urs;
        id_rt     = rt;
        id_use_rt = urt;
        id_rd     = rd;
        id_regwrt = rw;
        id_ctrl   = ct;
        id_halt   = hl;
        #1;
    endtask

    // Advance to the next low phase with EX quiet.
    task automatic nxt();
        @(negedge clk);
        ex_resolve  = 1'b0;
        ex_redirect = 1'b0;
    endtask

    // Asynchronous reset pulse in the low phase, leaving ID empty.
    task automatic do_reset();
        @(negedge clk);
        ex_resolve  = 1'b0;
        ex_redirect = 1'b0;
        rst = 1'b1;
        ins(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk_a("rst_ctl", 5'b00010);
        chk("rst_cnt", {16'd0, a_stall_cnt}, 32'd0);
        chk("rst_halted", {31'd0, a_halted}, 32'd0);
        chk_b("rst_ctl_b", 5'b00010);

        // Independent stream never stalls
        do_reset();
        ins(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
        chk_a("ind_1", 5'b00000);
        nxt();
        ins(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
        chk_a("ind_2", 5'b00000);
        nxt();
        ins(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
        chk_a("ind_3", 5'b00000);
        chk("ind_cnt", {16'd0, a_stall_cnt}, 32'd0);

        // ADD r3 then consumer of r3: a stalls 2 cycles, b stalls 3
        do_reset();
        ins(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        chk_a("raw_prod", 5'b00000);
        for (int c = 0; c < 4; c++) begin
            nxt();
            ins(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
            chk_a($sformatf("raw_a_c%0d", c), (c < 2) ? 5'b11010 : 5'b00000);
            chk_b($sformatf("raw_b_c%0d", c), (c < 3) ? 5'b11010 : 5'b00000);
        end
        chk("raw_cnt_a", {16'd0, a_stall_cnt}, 32'd2);
        chk("raw_cnt_b", {29'd0, b_stall_cnt}, 32'd3);

        // Store (no register write) followed by reader of its rd: no stall
        do_reset();
        ins(1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        chk_a("st_issue", 5'b00000);
        nxt();
        ins(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        chk_a("st_reader", 5'b00000);
        chk_b("st_reader_b", 5'b00000);

        // Branch: wait, resolve with redirect, back to RUN
        do_reset();
        ins(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        chk_a("br_issue", 5'b00000);
        nxt();
        ins(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        chk_a("br_wait", 5'b00110);
        nxt();
        ex_resolve = 1'b1; ex_redirect = 1'b1;
        ins(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        chk_a("br_resolve_redir", 5'b00111);
        nxt();
        ins(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0);
        chk_a("br_back_run", 5'b00000);
        // Second branch resolved without redirect
        nxt();
        ins(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        chk_a("br2_issue", 5'b00000);
        nxt();
        ex_resolve = 1'b1; ex_redirect = 1'b0;
        ins(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        chk_a("br2_resolve_noredir", 5'b00110);
        nxt();
        ex_resolve = 1'b1; ex_redirect = 1'b1;
        ins(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        chk_a("resolve_in_run_ignored", 5'b00000);
        nxt();
        ins(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0);
        chk_a("br2_run", 5'b00000);
        chk("br_cnt", {16'd0, a_stall_cnt}, 32'd3);

        // Branch dependent on preceding write; stray resolve during stall ignored
        do_reset();
        ins(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
        chk_a("brdep_prod", 5'b00000);
        nxt();
        ex_resolve = 1'b1; ex_redirect = 1'b1;
        ins(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        chk_a("brdep_stall1", 5'b11010);
        nxt();
        ins(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        chk_a("brdep_stall2", 5'b11010);
        nxt();
        ins(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        chk_a("brdep_issue", 5'b00000);
        nxt();
        ins(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        chk_a("brdep_wait", 5'b00110);
        nxt();
        ex_resolve = 1'b1; ex_redirect = 1'b1;
        ins(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        chk_a("brdep_resolve", 5'b00111);
        nxt();
        ins(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk_a("brdep_idle_run", 5'b00010);

        // HALT (also flagged ctrl) behind two writers: drain then halted
        do_reset();
        ins(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
        chk_a("halt_w1", 5'b00000);
        nxt();
        ins(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
        chk_a("halt_w2", 5'b00000);
        nxt();
        ins(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        chk_a("halt_issue", 5'b00010);
        for (int d = 0; d < 3; d++) begin
            nxt();
            ins(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
            chk_a($sformatf("drain_%0d", d), 5'b11010);
            chk($sformatf("drain_halted_%0d", d), {31'd0, a_halted}, 32'd0);
        end
        nxt();
        ins(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        chk_a("halted_ctl", 5'b11010);
        chk("halted_flag", {31'd0, a_halted}, 32'd1);
        nxt();
        ins(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        chk("halted_sticky", {31'd0, a_halted}, 32'd1);
        chk("halted_pchold", {31'd0, a_pc_hold}, 32'd1);
        chk("halt_cnt", {16'd0, a_stall_cnt}, 32'd4);
        // Asynchronous reset out of HALTED
        rst = 1'b1;
        ins(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_halted_flag", {31'd0, a_halted}, 32'd0);
        chk("rst_halted_cnt", {16'd0, a_stall_cnt}, 32'd0);
        chk_a("rst_halted_ctl", 5'b00010);
        rst = 1'b0;

        // Asynchronous reset while in DRAIN returns to RUN immediately
        do_reset();
        ins(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk_a("drst_halt", 5'b00010);
        nxt();
        ins(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk_a("drst_drain", 5'b11010);
        chk("drst_cnt_before", {16'd0, a_stall_cnt}, 32'd1);
        rst = 1'b1;
        #1;
        chk("drst_cnt", {16'd0, a_stall_cnt}, 32'd0);
        chk("drst_halted", {31'd0, a_halted}, 32'd0);
        chk_a("drst_run_ctl", 5'b00010);
        rst = 1'b0;

        // Idle bubbles count; b's 3-bit counter saturates at 7
        do_reset();
        for (int i = 0; i < 9; i++) begin
            nxt();
        end
        #1;
        chk("idle_cnt_a", {16'd0, a_stall_cnt}, 32'd9);
        chk("sat_cnt_b", {29'd0, b_stall_cnt}, 32'd7);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
